vend_dispense_ctrl: RTL and testbench
=====================================

Name: vend_dispense_ctrl

Overview:
Sequences the physical outputs of the vending machine core. On a one-cycle soda event carrying a 3-bit change code, it drives a handshake to the soda dispenser, then pays out change through nickel and dime hopper handshakes. It inhibits coin acceptance while busy, substitutes nickels when the dime hopper is empty, and traps timeouts and illegal codes in a sticky fault state. It sits between the vending machine core outputs and the dispenser/hopper actuators.

Parameters:
ACK_TIMEOUT, 64, cycles a request may wait for its ack before FAULT (>=2)
GAP_CYCLES, 2, idle cycles between consecutive coin requests (0 = no gap)
CNT_W, 16, width of the vend counter

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  asynchronous active-low reset
i_soda  input  1  one-cycle pulse from core: soda earned
i_change  input  3  change code at i_soda: 0..4 = 0/5/10/15/20 cents; 5..7 illegal
o_coin_inhibit  output  1  high while not IDLE; upstream must not present coins
o_vend_req  output  1  soda dispenser request
i_vend_ack  input  1  dispenser ack
o_nickel_req  output  1  nickel hopper request
o_dime_req  output  1  dime hopper request
i_hopper_ack  input  1  ack for whichever hopper request is active
i_dime_empty  input  1  dime hopper empty (level)
o_done  output  1  one-cycle pulse: transaction fully paid out
o_fault  output  1  sticky fault flag
o_fault_code  output  2  0 none, 1 illegal code, 2 vend timeout, 3 hopper timeout
i_fault_clr  input  1  clears FAULT
o_overrun  output  1  sticky: i_soda seen while not IDLE; cleared only by reset
o_vend_count  output  CNT_W  completed transactions, wraps to 0

Behaviour:
- Reset (async, i_rstn=0): state IDLE; all outputs 0; remaining=0; counters 0. All outputs registered.
- States: IDLE, VEND, COIN_REQ, COIN_GAP, FAULT.
- IDLE: i_soda=1 sampled at edge N -> i_change<=4: latch remaining = i_change*5 (5-bit cents), state VEND, o_vend_req=1 from cycle N+1. i_change>=5: state FAULT, o_fault_code=1, no vend.
- VEND: o_vend_req held until i_vend_ack sampled 1; req low the next cycle. Then remaining=0 -> IDLE with o_done pulse and o_vend_count+1 on same edge; else COIN_REQ.
- COIN_REQ entry selects coin: remaining>=10 and i_dime_empty=0 -> dime, else nickel. Selection is held for the whole request (i_dime_empty changes mid-request ignored). Exactly one of o_nickel_req/o_dime_req high.
- COIN_REQ: on i_hopper_ack=1, req drops next cycle, remaining -= 10 or 5. remaining=0 -> IDLE with o_done and count+1; else COIN_GAP (or directly COIN_REQ if GAP_CYCLES=0).
- COIN_GAP: exactly GAP_CYCLES cycles with both reqs low, then COIN_REQ.
- Timeout: per-request counter cleared on entering VEND/COIN_REQ; if ack not seen by ACK_TIMEOUT cycles of req high -> FAULT, code 2 (VEND) or 3 (COIN_REQ), all reqs low next cycle.
- Acks outside a matching request are ignored.
- FAULT: o_fault=1, o_coin_inhibit=1, reqs low, remaining retained. i_fault_clr=1 -> IDLE, o_fault=0, code=0, remaining=0, no o_done, counter unchanged.
- o_coin_inhibit = (state != IDLE), registered with state.
- i_soda while not IDLE: ignored, o_overrun set.
- Async reset mid-transaction aborts immediately; all reqs drop without waiting for ack.

Test Plan:
- Reset, i_soda with i_change=0, ack vend after 3 cycles -> o_vend_req high 3 cycles, then o_done pulse, o_vend_count=1, no hopper reqs.
- i_change=4 (20c), dime not empty, immediate acks, GAP_CYCLES=2 -> vend, dime, 2-cycle gap, dime, o_done; no nickel req.
- i_change=3 (15c) with i_dime_empty=1 -> three nickel requests, o_done after third ack; o_coin_inhibit high throughout.
- i_change=6 -> FAULT code 1, no o_vend_req; i_fault_clr -> IDLE, o_vend_count unchanged.
- i_change=2, withhold i_hopper_ack 64 cycles -> FAULT code 3 after vend ack; i_soda during FAULT sets o_overrun.
- Assert i_rstn=0 while o_dime_req high -> all outputs 0 immediately; new transaction then completes normally.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: drives the soda dispenser handshake, then pays out change
// through the nickel/dime hoppers, trapping timeouts and illegal codes in FAULT.
module vend_dispense_ctrl #(
  parameter int ACK_TIMEOUT = 64,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_soda,
  input  logic [2:0]       i_change,
  output logic             o_coin_inhibit,
  output logic             o_vend_req,
  input  logic             i_vend_ack,
  output logic             o_nickel_req,
  output logic             o_dime_req,
  input  logic             i_hopper_ack,
  input  logic             i_dime_empty,
  output logic             o_done,
  output logic             o_fault,
  output logic [1:0]       o_fault_code,
  input  logic             i_fault_clr,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_vend_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_COIN_REQ,
    S_COIN_GAP,
    S_FAULT
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_ILLEGAL  = 2'd1;
  localparam logic [1:0] FC_VEND_TMO = 2'd2;
  localparam logic [1:0] FC_HOP_TMO  = 2'd3;

  localparam int TMO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [4:0]         remaining_q, remaining_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               dime_sel_q, dime_sel_d;
  logic               inhibit_d, vend_req_d, nickel_req_d, dime_req_d, done_d;
  logic               fault_d, overrun_d;
  logic [1:0]         fault_code_d;
  logic [CNT_W-1:0]   count_d;

  logic               start_coin, finish;
  logic [4:0]         coin_rem, rem_after_coin, change_cents;

  // Change code times five, in cents; only codes 0..4 are ever latched.
  assign change_cents   = {i_change, 2'b00} + {2'b00, i_change};
  assign rem_after_coin = remaining_q - (dime_sel_q ? 5'd10 : 5'd5);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    remaining_d  = remaining_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    dime_sel_d   = dime_sel_q;
    fault_d      = o_fault;
    fault_code_d = o_fault_code;
    count_d      = o_vend_count;
    done_d       = 1'b0;
    start_coin   = 1'b0;
    finish       = 1'b0;
    coin_rem     = remaining_q;
    overrun_d    = o_overrun | (i_soda & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (i_soda) begin
          if (i_change <= 3'd4) begin
            remaining_d = change_cents;
            tmo_d       = '0;
            state_d     = S_VEND;
          end else begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_code_d = FC_ILLEGAL;
          end
        end
      end
      S_VEND: begin
        if (i_vend_ack) begin
          if (remaining_q == 5'd0) finish = 1'b1;
          else                     start_coin = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_FAULT;
          fault_d      = 1'b1;
          fault_code_d = FC_VEND_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_COIN_REQ: begin
        if (i_hopper_ack) begin
          remaining_d = rem_after_coin;
          if (rem_after_coin == 5'd0) begin
            finish = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            start_coin = 1'b1;
            coin_rem   = rem_after_coin;
          end else begin
            gap_d   = '0;
            state_d = S_COIN_GAP;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_FAULT;
          fault_d      = 1'b1;
          fault_code_d = FC_HOP_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_COIN_GAP: begin
        if (gap_q == GAP_LAST) start_coin = 1'b1;
        else                   gap_d = gap_q + GAP_W'(1);
      end
      S_FAULT: begin
        if (i_fault_clr) begin
          state_d      = S_IDLE;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
          remaining_d  = 5'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      count_d = o_vend_count + CNT_W'(1);
    end
    // Coin choice is frozen at request entry; later i_dime_empty changes are ignored.
    if (start_coin) begin
      state_d    = S_COIN_REQ;
      tmo_d      = '0;
      dime_sel_d = (coin_rem >= 5'd10) && !i_dime_empty;
    end

    inhibit_d    = (state_d != S_IDLE);
    vend_req_d   = (state_d == S_VEND);
    nickel_req_d = (state_d == S_COIN_REQ) && !dime_sel_d;
    dime_req_d   = (state_d == S_COIN_REQ) && dime_sel_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q        <= S_IDLE;
      remaining_q    <= 5'd0;
      tmo_q          <= '0;
      gap_q          <= '0;
      dime_sel_q     <= 1'b0;
      o_coin_inhibit <= 1'b0;
      o_vend_req     <= 1'b0;
      o_nickel_req   <= 1'b0;
      o_dime_req     <= 1'b0;
      o_done         <= 1'b0;
      o_fault        <= 1'b0;
      o_fault_code   <= FC_NONE;
      o_overrun      <= 1'b0;
      o_vend_count   <= '0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      tmo_q          <= tmo_d;
      gap_q          <= gap_d;
      dime_sel_q     <= dime_sel_d;
      o_coin_inhibit <= inhibit_d;
      o_vend_req     <= vend_req_d;
      o_nickel_req   <= nickel_req_d;
      o_dime_req     <= dime_req_d;
      o_done         <= done_d;
      o_fault        <= fault_d;
      o_fault_code   <= fault_code_d;
      o_overrun      <= overrun_d;
      o_vend_count   <= count_d;
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench for vend_dispense_ctrl: expected handshake events are queued
// at stimulus time and popped as the monitor sees requests, done pulses and faults.
module tb_vend_dispense_ctrl;

  localparam int ACK_TIMEOUT = 64;
  localparam int GAP_CYCLES  = 2;
  localparam int CNT_W       = 16;

  localparam int EV_VEND   = 1;
  localparam int EV_NICKEL = 2;
  localparam int EV_DIME   = 3;
  localparam int EV_DONE   = 4;
  localparam int EV_FAULT  = 8;

  logic             i_clk, i_rstn, i_soda, i_vend_ack, i_hopper_ack, i_dime_empty, i_fault_clr;
  logic [2:0]       i_change;
  logic             o_coin_inhibit, o_vend_req, o_nickel_req, o_dime_req, o_done, o_fault, o_overrun;
  logic [1:0]       o_fault_code;
  logic [CNT_W-1:0] o_vend_count;
  logic [8:0]       outs;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  int vend_delay = 1;
  int hop_delay  = 1;
  bit hop_en     = 1'b1;
  int vk, hk;

  bit vp, np, dp, fp, hp, hop, gap_armed;
  int vend_len, hop_len, gap_len, last_vend_len, last_hop_len;
  int inhib_err = 0;

  assign outs = {o_coin_inhibit, o_vend_req, o_nickel_req, o_dime_req, o_done,
                 o_fault, o_fault_code, o_overrun};

  vend_dispense_ctrl #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_soda        (i_soda),
    .i_change      (i_change),
    .o_coin_inhibit(o_coin_inhibit),
    .o_vend_req    (o_vend_req),
    .i_vend_ack    (i_vend_ack),
    .o_nickel_req  (o_nickel_req),
    .o_dime_req    (o_dime_req),
    .i_hopper_ack  (i_hopper_ack),
    .i_dime_empty  (i_dime_empty),
    .o_done        (o_done),
    .o_fault       (o_fault),
    .o_fault_code  (o_fault_code),
    .i_fault_clr   (i_fault_clr),
    .o_overrun     (o_overrun),
    .o_vend_count  (o_vend_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic ev(int e);
    if (exp_q.size() == 0) check("unexpected_event", e, 0);
    else                   check("event", e, exp_q.pop_front());
  endtask

  // Acknowledge responders: ack raised on the Nth low phase a request has been high.
  initial begin
    i_vend_ack   = 1'b0;
    i_hopper_ack = 1'b0;
    vk = 0;
    hk = 0;
    forever begin
      @(negedge i_clk);
      i_vend_ack   = 1'b0;
      i_hopper_ack = 1'b0;
      if (o_vend_req) begin
        vk++;
        if (vk >= vend_delay) begin
          i_vend_ack = 1'b1;
          vk = 0;
        end
      end else vk = 0;
      if ((o_nickel_req || o_dime_req) && hop_en) begin
        hk++;
        if (hk >= hop_delay) begin
          i_hopper_ack = 1'b1;
          hk = 0;
        end
      end else hk = 0;
    end
  end

  // Monitor: turns output edges into scoreboard events and measures pulse/gap lengths.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_rstn) begin
        vp = 0; np = 0; dp = 0; fp = 0; hp = 0;
        gap_armed = 0; vend_len = 0; hop_len = 0;
      end else begin
        hop = o_nickel_req | o_dime_req;
        if (o_vend_req && !vp)   ev(EV_VEND);
        if (o_nickel_req && !np) ev(EV_NICKEL);
        if (o_dime_req && !dp)   ev(EV_DIME);
        if (o_done)              ev(EV_DONE);
        if (o_fault && !fp)      ev(EV_FAULT + int'(o_fault_code));
        if (hop) check("one_coin_req", int'(o_nickel_req & o_dime_req), 0);
        if ((hop || o_vend_req) && !o_coin_inhibit) inhib_err++;

        if (o_vend_req) vend_len = vp ? vend_len + 1 : 1;
        else if (vp)    last_vend_len = vend_len;
        if (hop)        hop_len = hp ? hop_len + 1 : 1;
        else if (hp)    last_hop_len = hop_len;

        if (hop && !hp) begin
          if (gap_armed) check("coin_gap", gap_len, GAP_CYCLES);
          gap_armed = 0;
        end else if (!hop && hp) begin
          gap_armed = 1;
          gap_len   = 1;
        end else if (!hop && gap_armed) begin
          gap_len++;
        end
        if (o_done || o_fault) gap_armed = 0;

        vp = o_vend_req; np = o_nickel_req; dp = o_dime_req; fp = o_fault; hp = hop;
      end
    end
  end

  task automatic send(logic [2:0] chg);
    @(negedge i_clk);
    i_soda   = 1'b1;
    i_change = chg;
    @(negedge i_clk);
    i_soda   = 1'b0;
  endtask

  task automatic drain(string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge i_clk);
    #1;
  endtask

  task automatic clear_fault();
    @(negedge i_clk);
    i_fault_clr = 1'b1;
    @(negedge i_clk);
    i_fault_clr = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rstn       = 1'b0;
    i_soda       = 1'b0;
    i_change     = 3'd0;
    i_dime_empty = 1'b0;
    i_fault_clr  = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    check("rst_outs", int'(outs), 0);
    check("rst_count", int'(o_vend_count), 0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // 0c change: vend only, dispenser acks on third request cycle.
    vend_delay = 3;
    exp_q = '{EV_VEND, EV_DONE};
    send(3'd0);
    drain("t1");
    check("t1_vend_len", last_vend_len, 3);
    check("t1_count", int'(o_vend_count), 1);
    check("t1_done_pulse", int'(o_done), 0);
    check("t1_idle_inhibit", int'(o_coin_inhibit), 0);

    // 20c with dimes available: two dimes separated by the gap.
    vend_delay = 1;
    hop_delay  = 1;
    exp_q = '{EV_VEND, EV_DIME, EV_DIME, EV_DONE};
    send(3'd4);
    drain("t2");
    check("t2_count", int'(o_vend_count), 2);

    // 15c with the dime hopper empty: three nickels.
    i_dime_empty = 1'b1;
    exp_q = '{EV_VEND, EV_NICKEL, EV_NICKEL, EV_NICKEL, EV_DONE};
    send(3'd3);
    drain("t3");
    check("t3_count", int'(o_vend_count), 3);
    check("t3_inhibit_held", inhib_err, 0);
    i_dime_empty = 1'b0;

    // Illegal change code.
    exp_q = '{EV_FAULT + 1};
    send(3'd6);
    drain("t4");
    check("t4_fault", int'(o_fault), 1);
    check("t4_code", int'(o_fault_code), 1);
    check("t4_inhibit", int'(o_coin_inhibit), 1);
    clear_fault();
    check("t4_clr_fault", int'(o_fault), 0);
    check("t4_clr_code", int'(o_fault_code), 0);
    check("t4_clr_inhibit", int'(o_coin_inhibit), 0);
    check("t4_count", int'(o_vend_count), 3);
    check("t4_overrun", int'(o_overrun), 0);

    // Hopper never acks: timeout fault, then a soda during FAULT flags overrun.
    hop_en = 1'b0;
    exp_q = '{EV_VEND, EV_DIME, EV_FAULT + 3};
    send(3'd2);
    drain("t5");
    check("t5_hop_len", last_hop_len, ACK_TIMEOUT);
    check("t5_code", int'(o_fault_code), 3);
    send(3'd0);
    #1;
    check("t5_overrun", int'(o_overrun), 1);
    check("t5_fault_held", int'(o_fault), 1);
    check("t5_vend_idle", int'(o_vend_req), 0);
    clear_fault();
    check("t5_clr_fault", int'(o_fault), 0);
    check("t5_count", int'(o_vend_count), 3);
    hop_en = 1'b1;

    // Async reset while a dime request is outstanding, then a clean 5c transaction.
    hop_delay = 5;
    exp_q = '{EV_VEND, EV_DIME, EV_DIME, EV_DONE};
    send(3'd4);
    begin
      int n = 0;
      while (!o_dime_req && n < 50) begin
        @(negedge i_clk);
        n++;
      end
    end
    check("t6_dime_seen", int'(o_dime_req), 1);
    #2;
    i_rstn = 1'b0;
    #1;
    check("t6_rst_outs", int'(outs), 0);
    check("t6_rst_count", int'(o_vend_count), 0);
    exp_q.delete();
    @(negedge i_clk);
    i_rstn    = 1'b1;
    hop_delay = 1;
    exp_q = '{EV_VEND, EV_NICKEL, EV_DONE};
    send(3'd1);
    drain("t6");
    check("t6_count", int'(o_vend_count), 1);
    check("t6_overrun", int'(o_overrun), 0);
    check("t6_inhibit_held", inhib_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
